// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and ALU-code definitions for the multicycle controller
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps an R-type funct field to the ALU control code and flags unsupported functs
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);
    always_comb begin
        alu_control = ALU_ADD;
        valid = 1'b1;
        case (funct)
            F_ADD:   alu_control = ALU_ADD;
            F_SUB:   alu_control = ALU_SUB;
            F_AND:   alu_control = ALU_AND;
            F_OR:    alu_control = ALU_OR;
            F_SLT:   alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing the shared ALU, memory, IR and register file,
// with a wait counter stretching each memory-access state to MEM_WAIT+1 cycles.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal
);
    state_t state, state_next;
    logic [2:0] cnt;
    logic [2:0] funct_alu;
    logic funct_ok, op_ok, last;
    logic pc_write, branch, mem_write_i, ir_write_i, reg_write_i, illegal_i;

    alu_decoder u_alu_decoder (.funct(funct), .alu_control(funct_alu), .valid(funct_ok));

    assign last  = cnt == 3'(MEM_WAIT);
    assign op_ok = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt <= '0;
        end else begin
            state <= state_next;
            cnt <= (state_next != state) ? 3'd0 : (cnt < 3'(MEM_WAIT)) ? cnt + 3'd1 : cnt;
        end
    end

    always_comb begin
        state_next = state;
        iord = 1'b0;
        reg_dst = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_REG;
        pc_src = PC_ALU;
        alu_control = ALU_ADD;
        pc_write = 1'b0;
        branch = 1'b0;
        mem_write_i = 1'b0;
        ir_write_i = 1'b0;
        reg_write_i = 1'b0;
        illegal_i = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write_i = last;
                pc_write = last;
                state_next = last ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                illegal_i = !op_ok;
                state_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                             (op == OP_ADDI) ? ADDIEX :
                             (op == OP_R)    ? EXEC :
                             (op == OP_BEQ)  ? BRANCH :
                             (op == OP_J)    ? JUMP : FETCH;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord = 1'b1;
                state_next = last ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write_i = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                iord = 1'b1;
                mem_write_i = last;
                state_next = last ? FETCH : MEMWRITE;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_control = funct_alu;
                illegal_i = !funct_ok;
                state_next = funct_ok ? ALUWB : FETCH;
            end
            ALUWB: begin
                reg_dst = 1'b1;
                reg_write_i = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_control = ALU_SUB;
                pc_src = PC_ALUOUT;
                branch = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write_i = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src = PC_JUMP;
                pc_write = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Strobes are forced low while reset is held, whatever state is being left
    assign pc_en     = !reset && (pc_write || (branch && zero));
    assign mem_write = !reset && mem_write_i;
    assign ir_write  = !reset && ir_write_i;
    assign reg_write = !reset && reg_write_i;
    assign illegal   = !reset && illegal_i;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: drives instruction streams into MEM_WAIT=0 and MEM_WAIT=2 instances
// and compares every cycle against a per-instruction expected-output schedule.
module tb_multicycle_control;
    localparam logic [15:0] PW = 16'h8000, IORD = 16'h4000, MW = 16'h2000, IRW = 16'h1000;
    localparam logic [15:0] RD = 16'h0800, M2R = 16'h0400, RW = 16'h0200, SA = 16'h0100;
    localparam logic [15:0] SB4 = 16'h0040, SBI = 16'h0080, SBS = 16'h00C0;
    localparam logic [15:0] PCO = 16'h0010, PCJ = 16'h0020, SUB = 16'h0002, ILL = 16'h0001;
    localparam logic [15:0] STROBES = PW | MW | IRW | RW | ILL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset [2];
    logic [5:0] op [2];
    logic [5:0] funct [2];
    logic zero [2];
    logic [15:0] outv [2];
    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [$];
    logic br_q [$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
        logic [1:0] alu_src_b, pc_src;
        logic [2:0] alu_control;
        multicycle_control #(.MEM_WAIT(g * 2)) dut (
            .clk(clk), .reset(reset[g]), .op(op[g]), .funct(funct[g]), .zero(zero[g]),
            .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
            .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
            .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
            .alu_control(alu_control), .illegal(illegal)
        );
        assign outv[g] = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                          alu_src_a, alu_src_b, pc_src, alu_control, illegal};
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] alu_bits(input logic [5:0] f);
        case (f)
            6'h22:   return 16'h0002;
            6'h24:   return 16'h0004;
            6'h25:   return 16'h0006;
            6'h2A:   return 16'h000A;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push(input logic [15:0] e, input logic b);
        exp_q.push_back(e);
        br_q.push_back(b);
    endtask

    // Expected per-cycle outputs for one instruction; pc_en bit holds pc_write, branch kept aside
    task automatic build(input logic [5:0] o, input logic [5:0] f, input int w);
        logic f_ok;
        f_ok = f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        exp_q.delete();
        br_q.delete();
        for (int i = 0; i <= w; i++) push(SB4 | ((i == w) ? (PW | IRW) : 16'h0), 1'b0);
        if (!(o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02})) begin
            push(SBS | ILL, 1'b0);
            return;
        end
        push(SBS, 1'b0);
        case (o)
            6'h23, 6'h2B: begin
                push(SA | SBI, 1'b0);
                for (int i = 0; i <= w; i++) push(IORD | ((o == 6'h2B && i == w) ? MW : 16'h0), 1'b0);
                if (o == 6'h23) push(M2R | RW, 1'b0);
            end
            6'h00: begin
                push(SA | alu_bits(f) | (f_ok ? 16'h0 : ILL), 1'b0);
                if (f_ok) push(RD | RW, 1'b0);
            end
            6'h04: push(SA | SUB | PCO, 1'b1);
            6'h08: begin
                push(SA | SBI, 1'b0);
                push(RW, 1'b0);
            end
            default: push(PCJ | PW, 1'b0);
        endcase
    endtask

    // Tasks start and end on a falling edge
    task automatic do_reset(input int d);
        reset[d] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            zero[d] = 1'($urandom_range(0, 1));
            #2 check($sformatf("dut%0d_reset_strobes_c%0d", d, i), outv[d] & STROBES, 16'h0);
            @(negedge clk);
        end
        reset[d] = 1'b0;
    endtask

    task automatic run(input int d, input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort_at);
        logic [15:0] want;
        build(o, f, d * 2);
        for (int i = 0; i < exp_q.size(); i++) begin
            op[d] = o;
            funct[d] = f;
            zero[d] = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                do_reset(d);
                return;
            end
            want = exp_q[i] | {br_q[i] & zero[d], 15'h0};
            #2 check($sformatf("dut%0d_op%02h_f%02h_z%0d_c%0d", d, o, f, zero[d], i), outv[d], want);
            @(negedge clk);
        end
    endtask

    task automatic random_instr(input int d);
        logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] o, f;
        int r;
        r = int'($urandom_range(0, 7));
        o = (r < 6) ? ops[r] : (r == 6) ? 6'($urandom) : 6'h00;
        r = int'($urandom_range(0, 6));
        f = (r < 5) ? fns[r] : 6'($urandom);
        run(d, o, f, 0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            op[d] = 6'h00;
            funct[d] = 6'h20;
            zero[d] = 1'b0;
        end
        @(negedge clk);
        do_reset(0);
        run(0, 6'h00, 6'h20, 1, -1);
        run(0, 6'h04, 6'h00, 1, -1);
        run(0, 6'h04, 6'h00, 2, -1);
        run(0, 6'h02, 6'h00, 1, -1);
        run(0, 6'h00, 6'h2A, 1, -1);
        run(0, 6'h3F, 6'h20, 1, -1);
        run(0, 6'h00, 6'h3F, 1, -1);
        run(0, 6'h23, 6'h00, 1, -1);
        run(0, 6'h2B, 6'h00, 1, -1);
        run(0, 6'h08, 6'h00, 1, -1);
        for (int i = 0; i < 80; i++) random_instr(0);
        reset[0] = 1'b1;
        do_reset(1);
        run(1, 6'h23, 6'h00, 0, -1);
        run(1, 6'h23, 6'h00, 0, 6);
        run(1, 6'h23, 6'h00, 0, -1);
        run(1, 6'h2B, 6'h00, 0, -1);
        run(1, 6'h04, 6'h00, 1, -1);
        for (int i = 0; i < 60; i++) random_instr(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
